sync_fifo_prog: RTL and testbench

Single-clock, parametrised FIFO. It is the next generation of the team's FIFO, intended for same-clock producer/consumer paths where the gray-code CDC machinery is not needed.
- Adds a selectable read mode: standard (registered output) or first-word-fall-through (FWFT).
- Adds run-time programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and a high-water-mark statistic.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_mem.sv | 25 ++
 rtl/sync_fifo_prog.sv | 145 ++++++++++++++
 tb/tb_sync_fifo_prog.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode codes and width helpers.
// Used by the sync FIFO and the async FIFO family.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Occupancy must hold 0..DEPTH, so one bit wider than a pointer.
  function automatic int occ_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DATA_WIDTH x 2^ADDR_WIDTH, sync write, async read.
// Ports: clk, wr_en/wr_addr/wr_data write port, rd_addr -> rd_data.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO, std or FWFT read, programmable AF/AE, stats.
// Ports: clk/rst_n/flush, wr/rd handshake, flags, count, max_count.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   max_count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_stat
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = occ_width(ADDR_WIDTH);

  localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         max_q, max_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd;

  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign count        = count_q;
  assign max_count    = max_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Set wins over clear so an event in the clear cycle is not lost.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_stat) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en & full & ~flush)  ovf_d = 1'b1;
    if (rd_en & empty & ~flush) udf_d = 1'b1;
  end

  always_comb begin
    max_d = max_q;
    if (clr_stat)              max_d = count_d;
    else if (count_d > max_q)  max_d = count_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd)
  );

  generate
    if (FWFT == FIFO_MODE_STD) begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) rd_data_d = mem_rd;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
      end

      assign rd_data = rd_data_q;
    end else begin : g_fwft
      // Head word shows through; forced to 0 so stale RAM never leaks.
      assign rd_data = empty ? '0 : mem_rd;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: std and FWFT instances share
// stimulus; each check compares against hand-computed values.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n, flush, wr_en, rd_en, clr_stat;
  logic [7:0] wr_data;
  logic [2:0] af_thresh, ae_thresh;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0] s_count, s_max, f_count, f_max;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .full(s_full), .empty(s_empty),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .max_count(s_max),
    .overflow(s_ovf), .underflow(s_udf), .clr_stat(clr_stat)
  );

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .full(f_full), .empty(f_empty),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .max_count(f_max),
    .overflow(f_ovf), .underflow(f_udf), .clr_stat(clr_stat)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; inputs are released #1 after the edge, then checked.
  task automatic tick();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    flush    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    clr_stat = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    clr_stat = 1'b0; wr_data = 8'h00;
    af_thresh = 3'd3; ae_thresh = 3'd1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    tick();

    chk("rst_count", s_count, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_ae", s_ae, 1);
    chk("rst_af", s_af, 0);
    chk("rst_rd_data", s_rd_data, 8'h00);
    chk("rst_fwft_rd", f_rd_data, 8'h00);
    chk("rst_flags", {s_ovf, s_udf, s_max}, 0);

    // Fill / drain
    push(8'h11);
    chk("fill1_count", s_count, 1);
    chk("fill1_ae", s_ae, 1);
    chk("fill1_fwft_head", f_rd_data, 8'h11);
    push(8'h22);
    chk("fill2_ae", s_ae, 0);
    chk("fill2_af", s_af, 0);
    push(8'h33);
    chk("fill3_af", s_af, 1);
    chk("fill3_full", s_full, 0);
    push(8'h44);
    chk("fill4_count", s_count, 4);
    chk("fill4_full", s_full, 1);
    chk("fill4_fwft_head", f_rd_data, 8'h11);
    pop();
    chk("drain1_data", s_rd_data, 8'h11);
    chk("drain1_count", s_count, 3);
    chk("drain1_fwft_head", f_rd_data, 8'h22);
    pop();
    chk("drain2_data", s_rd_data, 8'h22);
    pop();
    chk("drain3_data", s_rd_data, 8'h33);
    pop();
    chk("drain4_data", s_rd_data, 8'h44);
    chk("drain4_empty", s_empty, 1);
    chk("drain4_count", s_count, 0);
    chk("drain4_fwft_zero", f_rd_data, 8'h00);
    chk("drain_max", s_max, 4);

    // FWFT head visibility
    push(8'hA5);
    chk("fwft_empty", f_empty, 0);
    chk("fwft_head", f_rd_data, 8'hA5);
    chk("std_holds", s_rd_data, 8'h44);
    pop();
    chk("fwft_pop_empty", f_empty, 1);
    chk("fwft_pop_zero", f_rd_data, 8'h00);
    chk("std_pop_data", s_rd_data, 8'hA5);

    // Overflow / underflow
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wr_en = 1'b1; wr_data = 8'h55; rd_en = 1'b1;
    tick();
    chk("ovf_count", s_count, 3);
    chk("ovf_flag", s_ovf, 1);
    chk("ovf_rd", s_rd_data, 8'h01);
    chk("ovf_fwft_flag", f_ovf, 1);
    pop();
    chk("ovf_drain1", s_rd_data, 8'h02);
    pop();
    chk("ovf_drain2", s_rd_data, 8'h03);
    pop();
    chk("ovf_drain3", s_rd_data, 8'h04);
    chk("ovf_sticky", s_ovf, 1);
    wr_en = 1'b1; wr_data = 8'h66; rd_en = 1'b1;
    tick();
    chk("udf_flag", s_udf, 1);
    chk("udf_wr_acc", s_count, 1);
    chk("udf_rd_hold", s_rd_data, 8'h04);
    pop();
    chk("udf_pop_data", s_rd_data, 8'h66);
    rd_en = 1'b1; clr_stat = 1'b1;
    tick();
    chk("udf_set_wins", s_udf, 1);
    chk("ovf_cleared", s_ovf, 0);
    chk("clr_max", s_max, 0);
    clr_stat = 1'b1;
    tick();
    chk("udf_cleared", s_udf, 0);

    // Wrap-around with count held at 2
    push(8'h60); push(8'h61);
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'h62 + 8'(i); rd_en = 1'b1;
      tick();
      chk($sformatf("wrap%0d_data", i), s_rd_data, 32'h60 + i);
      chk($sformatf("wrap%0d_count", i), s_count, 2);
    end
    chk("wrap_fwft_head", f_rd_data, 8'h6A);
    pop();
    chk("wrap_tail1", s_rd_data, 8'h6A);
    pop();
    chk("wrap_tail2", s_rd_data, 8'h6B);
    chk("wrap_max", s_max, 2);

    // Flush and stats
    clr_stat = 1'b1;
    tick();
    chk("pre_flush_max", s_max, 0);
    push(8'h71); push(8'h72); push(8'h73);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick();
    chk("flush_count", s_count, 0);
    chk("flush_empty", s_empty, 1);
    chk("flush_ovf", s_ovf, 0);
    chk("flush_max", s_max, 3);
    chk("flush_rd_hold", s_rd_data, 8'h6B);
    chk("flush_fwft_zero", f_rd_data, 8'h00);
    clr_stat = 1'b1;
    tick();
    chk("flush_clr_max", s_max, 0);
    push(8'h81);
    chk("post_flush_head", f_rd_data, 8'h81);
    pop();
    chk("post_flush_data", s_rd_data, 8'h81);

    // Flush while full and with rd_en on empty: no flags
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    chk("flush_full_ovf", s_ovf, 0);
    flush = 1'b1; rd_en = 1'b1;
    tick();
    chk("flush_empty_udf", s_udf, 0);

    // Thresholds act immediately
    af_thresh = 3'd0; ae_thresh = 3'd0;
    #1;
    chk("af_zero", s_af, 1);
    chk("ae_zero", s_ae, 1);
    push(8'hC0);
    chk("ae_zero_cnt1", s_ae, 0);
    af_thresh = 3'd2;
    #1;
    chk("af_two_cnt1", s_af, 0);
    af_thresh = 3'd3; ae_thresh = 3'd1;
    pop();

    // Reset mid-stream
    push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
    push(8'hD4);
    chk("pre_rst_ovf", s_ovf, 1);
    pop(); pop();
    chk("pre_rst_count", s_count, 2);
    chk("pre_rst_data", s_rd_data, 8'hD1);
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    chk("rst_mid_count", s_count, 0);
    chk("rst_mid_empty", s_empty, 1);
    chk("rst_mid_rd", s_rd_data, 8'h00);
    chk("rst_mid_flags", {s_ovf, s_udf}, 0);
    chk("rst_mid_max", s_max, 0);
    chk("rst_mid_fwft", {f_empty, f_rd_data}, 9'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
